stopwatch_bcd: RTL and testbench

Parametrised BCD stopwatch/countdown timer with seven-segment outputs. It is the successor to the fixed 4-digit timer in the clock display path. It counts a configurable number of decimal digits at a prescaled tick rate, in up or down mode, and supports start/stop, lap-freeze, clear and preset load. It sits between the board clock/button conditioning and the seven-segment drivers.

---
 rtl/clock_pkg.sv | 47 ++++
 rtl/bcd_to_seg7.sv | 11 +
 rtl/stopwatch_bcd.sv | 185 ++++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock display path: stopwatch states and seven-segment patterns.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } sw_state_e;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;

  // Non-decimal nibbles blank the digit.
  function automatic logic [SEG_W-1:0] seg7_pattern(input logic [DIGIT_W-1:0] v);
    logic [SEG_W-1:0] p;
    case (v)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Single-digit BCD to seven-segment decoder, purely combinational.
module bcd_to_seg7
  import clock_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd_i,
  output logic [SEG_W-1:0]   seg_c
);

  assign seg_c = seg7_pattern(bcd_i);

endmodule

// File: rtl/stopwatch_bcd.sv
// Multi-digit BCD stopwatch / countdown timer with run, pause, lap-freeze, clear and preset load.
// Count, display and pulse outputs are registered; seg is decoded from the display register.
module stopwatch_bcd
  import clock_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned TICK_DIV       = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic                  lap,
  input  logic                  clear,
  input  logic                  down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [7*DIGITS-1:0]   seg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  running,
  output logic                  wrap,
  output logic                  expired
);

  localparam int unsigned CW = DIGIT_W * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};

  sw_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   disp_q, disp_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            freeze_q, freeze_d;
  logic            running_q, running_d;
  logic            wrap_q, wrap_d;
  logic            expired_q, expired_d;
  logic            ss_cur_q, ss_prev_q;
  logic            lap_cur_q, lap_prev_q;
  logic            seg_on_q;

  logic [CW-1:0]   inc_c, dec_c, preset_sat_c;
  logic [DIGITS:0] carry_c, borrow_c;
  logic            ss_edge_c, lap_edge_c, cnt_zero_c, dec_zero_c, all_nine_c;

  assign ss_edge_c  = ss_cur_q & ~ss_prev_q;
  assign lap_edge_c = lap_cur_q & ~lap_prev_q;

  // Ripple carry/borrow chains for the BCD counter, plus per-digit decode.
  assign carry_c[0]  = 1'b1;
  assign borrow_c[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [DIGIT_W-1:0] d;
    logic [DIGIT_W-1:0] p;
    logic [SEG_W-1:0]   pat;

    assign d = count_q[DIGIT_W*i +: DIGIT_W];
    assign p = preset[DIGIT_W*i +: DIGIT_W];

    assign inc_c[DIGIT_W*i +: DIGIT_W] = !carry_c[i] ? d :
                                         (d == 4'd9) ? 4'd0 : d + 4'd1;
    assign carry_c[i+1] = carry_c[i] & (d == 4'd9);

    assign dec_c[DIGIT_W*i +: DIGIT_W] = !borrow_c[i] ? d :
                                         (d == 4'd0) ? 4'd9 : d - 4'd1;
    assign borrow_c[i+1] = borrow_c[i] & (d == 4'd0);

    assign preset_sat_c[DIGIT_W*i +: DIGIT_W] = (p > 4'd9) ? 4'd9 : p;

    bcd_to_seg7 u_seg7 (
      .bcd_i (disp_q[DIGIT_W*i +: DIGIT_W]),
      .seg_c (pat)
    );

    assign seg[SEG_W*i +: SEG_W] = seg_on_q ? (pat ^ SEG_OFF) : SEG_OFF;
  end

  assign all_nine_c = carry_c[DIGITS];
  assign cnt_zero_c = borrow_c[DIGITS];
  assign dec_zero_c = (dec_c == '0);

  // Next-state: clear > load > start_stop > lap > tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    freeze_d  = freeze_q;
    disp_d    = freeze_q ? disp_q : count_q;
    wrap_d    = 1'b0;
    expired_d = 1'b0;
    running_d = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      presc_d  = '0;
      freeze_d = 1'b0;
      disp_d   = '0;
    end else if (load && (state_q == ST_IDLE || state_q == ST_PAUSE || state_q == ST_DONE)) begin
      state_d = ST_PAUSE;
      count_d = preset_sat_c;
      disp_d  = preset_sat_c;
      presc_d = '0;
    end else if (ss_edge_c && state_q != ST_DONE) begin
      case (state_q)
        ST_IDLE, ST_PAUSE: state_d = ST_RUN;
        ST_RUN, ST_LAP:    state_d = ST_PAUSE;
        default:           state_d = state_q;
      endcase
    end else begin
      if (lap_edge_c) begin
        case (state_q)
          ST_RUN: begin
            state_d  = ST_LAP;
            freeze_d = 1'b1;
          end
          ST_LAP: begin
            state_d  = ST_RUN;
            freeze_d = 1'b0;
          end
          default: freeze_d = 1'b0;
        endcase
      end
      if (state_q == ST_RUN || state_q == ST_LAP) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (down) begin
            if (!cnt_zero_c) count_d = dec_c;
            if (cnt_zero_c || dec_zero_c) begin
              expired_d = 1'b1;
              state_d   = ST_DONE;
            end
          end else begin
            count_d = inc_c;
            wrap_d  = all_nine_c;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end

    running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
  end

  // All state, including the input edge-detect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      disp_q     <= '0;
      presc_q    <= '0;
      freeze_q   <= 1'b0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
      expired_q  <= 1'b0;
      ss_cur_q   <= 1'b0;
      ss_prev_q  <= 1'b0;
      lap_cur_q  <= 1'b0;
      lap_prev_q <= 1'b0;
      seg_on_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      disp_q     <= disp_d;
      presc_q    <= presc_d;
      freeze_q   <= freeze_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
      expired_q  <= expired_d;
      ss_cur_q   <= start_stop;
      ss_prev_q  <= ss_cur_q;
      lap_cur_q  <= lap;
      lap_prev_q <= lap_cur_q;
      seg_on_q   <= 1'b1;
    end
  end

  assign bcd     = disp_q;
  assign running = running_q;
  assign wrap    = wrap_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd (4 digits, tick every 4 clocks): directed scenarios
// followed by random stimulus, all compared every cycle against an integer reference model.
module tb_stopwatch_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic        down = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset = '0;
  logic [27:0] seg;
  logic [15:0] bcd;
  logic        running, wrap, expired;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_bcd #(.DIGITS(4), .TICK_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .down(down), .load(load), .preset(preset), .seg(seg), .bcd(bcd),
    .running(running), .wrap(wrap), .expired(expired)
  );

  always #5 clk = ~clk;

  // Reference model: count and display held as plain integers 0..9999.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3, M_DONE = 4;
  int m_state, m_count, m_disp, m_presc;
  bit m_freeze, m_wrap, m_exp, m_seg_on;
  bit m_ss_cur, m_ss_prev, m_lap_cur, m_lap_prev;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int sat_value(input logic [15:0] p);
    int v;
    int d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [27:0] exp_seg();
    logic [27:0] s;
    logic [15:0] b;
    s = '0;
    b = to_bcd(m_disp);
    if (m_seg_on)
      for (int i = 0; i < 4; i++) s[7*i +: 7] = seg_of(b[4*i +: 4]);
    return s;
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE; m_count = 0; m_disp = 0; m_presc = 0;
    m_freeze = 0; m_wrap = 0; m_exp = 0; m_seg_on = 0;
    m_ss_cur = 0; m_ss_prev = 0; m_lap_cur = 0; m_lap_prev = 0;
  endfunction

  function automatic void model_update();
    bit ss_e, lap_e, counting;
    int new_disp;
    ss_e  = m_ss_cur && !m_ss_prev;
    lap_e = m_lap_cur && !m_lap_prev;
    m_ss_prev = m_ss_cur;   m_ss_cur = start_stop;
    m_lap_prev = m_lap_cur; m_lap_cur = lap;
    m_wrap = 0; m_exp = 0; m_seg_on = 1;
    new_disp = m_freeze ? m_disp : m_count;
    if (clear) begin
      m_state = M_IDLE; m_count = 0; m_presc = 0; m_freeze = 0; new_disp = 0;
    end else if (load && (m_state == M_IDLE || m_state == M_PAUSE || m_state == M_DONE)) begin
      m_state = M_PAUSE; m_count = sat_value(preset); new_disp = m_count; m_presc = 0;
    end else if (ss_e && m_state != M_DONE) begin
      m_state = (m_state == M_IDLE || m_state == M_PAUSE) ? M_RUN : M_PAUSE;
    end else begin
      counting = (m_state == M_RUN || m_state == M_LAP);
      if (lap_e) begin
        if (m_state == M_RUN) begin m_state = M_LAP; m_freeze = 1; end
        else if (m_state == M_LAP) begin m_state = M_RUN; m_freeze = 0; end
        else m_freeze = 0;
      end
      if (counting) begin
        if (m_presc == 3) begin
          m_presc = 0;
          if (down) begin
            if (m_count <= 1) begin m_count = 0; m_exp = 1; m_state = M_DONE; end
            else m_count = m_count - 1;
          end else begin
            m_wrap = (m_count == 9999);
            m_count = (m_count + 1) % 10000;
          end
        end else begin
          m_presc = m_presc + 1;
        end
      end
    end
    m_disp = new_disp;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    bit m_run;
    m_run = (m_state == M_RUN || m_state == M_LAP);
    check("bcd", 32'(bcd), 32'(to_bcd(m_disp)));
    check("seg", 32'(seg), 32'(exp_seg()));
    check("running", 32'(running), 32'(m_run));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("expired", 32'(expired), 32'(m_exp));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset(); else model_update();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press_ss();
    start_stop = 1'b1; step();
    start_stop = 1'b0; step();
  endtask

  task automatic press_lap();
    lap = 1'b1; step();
    lap = 1'b0; step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    preset = v; load = 1'b1; step(); load = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_bcd", 32'(bcd), 32'h0);
    check("reset_seg", 32'(seg), 32'h0);
    check_all();
    steps(2);
    reset = 1'b0;
    steps(2);

    // Count up from IDLE
    press_ss();
    check("run_rise", 32'(running), 32'h1);
    steps(41);
    check("up_0010", 32'(bcd), 32'h0010);
    check("seg_d0", 32'(seg[6:0]), 32'h3F);
    check("seg_d1", 32'(seg[13:7]), 32'h06);

    // Up wrap from 9998
    pulse_clear();
    do_load(16'h9998);
    check("load_9998", 32'(bcd), 32'h9998);
    press_ss();
    steps(8);
    check("wrap_pulse", 32'(wrap), 32'h1);
    step();
    check("wrap_0000", 32'(bcd), 32'h0000);
    check("wrap_single", 32'(wrap), 32'h0);
    steps(4);
    check("wrap_0001", 32'(bcd), 32'h0001);

    // Countdown to expiry; start_stop ignored in DONE
    pulse_clear();
    down = 1'b1;
    do_load(16'h0003);
    press_ss();
    steps(12);
    check("expired_pulse", 32'(expired), 32'h1);
    check("done_stopped", 32'(running), 32'h0);
    step();
    check("down_0000", 32'(bcd), 32'h0000);
    press_ss();
    steps(8);
    check("done_ignore_ss", 32'(running), 32'h0);

    // Lap freeze and release
    pulse_clear();
    down = 1'b0;
    press_ss();
    steps(20);
    press_lap();
    steps(26);
    check("lap_frozen", 32'(bcd), 32'h0005);
    press_lap();
    step();
    check("lap_release", 32'(bcd), 32'h0012);

    // Pause with prescaler at 2, then resume
    pulse_clear();
    press_ss();
    step();
    press_ss();
    check("paused", 32'(running), 32'h0);
    steps(50);
    press_ss();
    steps(2);
    check("resume_pre", 32'(bcd), 32'h0000);
    step();
    check("resume_tick", 32'(bcd), 32'h0001);

    // clear beats start_stop in the same cycle
    start_stop = 1'b1; step();
    start_stop = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    check("clear_wins", 32'(running), 32'h0);
    steps(5);
    check("clear_idle", 32'(bcd), 32'h0000);

    // Preset saturation
    do_load(16'hFA3C);
    check("preset_sat", 32'(bcd), 32'h9939);

    // Asynchronous reset while counting at 0123
    do_load(16'h0123);
    press_ss();
    steps(3);
    #2 reset = 1'b1;
    #1 model_reset();
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_pulses", 32'({wrap, expired}), 32'h0);
    steps(2);
    reset = 1'b0;

    // Random stimulus
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 11) == 0) lap = ~lap;
      if ($urandom_range(0, 49) == 0) down = ~down;
      clear = ($urandom_range(0, 119) == 0);
      load  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: preset = 16'h9997;
        1: preset = 16'h0002;
        2: preset = 16'h0000;
        default: preset = 16'($urandom);
      endcase
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
